diag_tile_sequencer: RTL and testbench
======================================

Name: diag_tile_sequencer

Overview:
- Initiator side of the diagnostic tile decode handshake.
- Takes a frame-level start and frame dimensions, splits the frame into raster-ordered tiles, and issues one start pulse per tile to the tile decoder.
- Waits for each tile_done before issuing the next tile; enforces a per-tile timeout.
- Reports frame completion or timeout to the frame controller.

Parameters:
TILE_W, 64, nominal tile width in pixels
TILE_H, 64, nominal tile height in pixels
TIMEOUT_CYCLES, 1000, max cycles in WAIT before timeout error
CNT_W, 16, width of timeout counter and tiles_completed

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
frame_start  input  1  single-cycle request to decode a frame
frame_width  input  16  frame width in pixels, sampled with frame_start
frame_height  input  16  frame height in pixels, sampled with frame_start
busy  output  1  high from accept through last tile_done or error
frame_done  output  1  one-cycle pulse on successful frame completion
timeout_err  output  1  sticky error flag; cleared by next accepted frame_start
tile_start  output  1  one-cycle pulse to tile decoder
tile_x  output  16  current tile origin x
tile_y  output  16  current tile origin y
tile_w  output  16  current tile width: min(TILE_W, frame_width - tile_x)
tile_h  output  16  current tile height: min(TILE_H, frame_height - tile_y)
tile_done  input  1  tile decoder completion (level or pulse, sampled in WAIT only)
tiles_completed  output  CNT_W  tiles finished in current or last frame

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: state=IDLE; busy, frame_done, timeout_err, tile_start = 0; tile_x/y/w/h = 0; tiles_completed = 0; timeout counter = 0.
- States: IDLE, ISSUE, WAIT, NEXT, DONE, ERR.
- IDLE:
  - frame_start=1 latches dims, clears timeout_err and tiles_completed, sets busy.
  - If either dim is 0, go to DONE (no tile issued).
  - Otherwise load tile_x=tile_y=0 with clipped w/h, then go to ISSUE.
- ISSUE (exactly 1 cycle): tile_start=1. Go to WAIT; timeout counter cleared.
- tile_start latency: tile_start is high in the cycle immediately after the edge that samples frame_start.
- tile_x/y/w/h hold stable from ISSUE entry until the NEXT update.
- WAIT:
  - tile_done=1: tiles_completed+1, go to NEXT.
  - Otherwise counter+1; when counter reaches TIMEOUT_CYCLES-1 without tile_done, go to ERR.
  - tile_done and timeout on the same cycle: tile_done wins.
- tile_done outside WAIT is ignored, including during the ISSUE cycle.
- NEXT (1 cycle): nx = tile_x + TILE_W, computed in 17 bits to avoid overflow.
  - If nx < width: tile_x=nx and go to ISSUE.
  - Else tile_x=0, ny = tile_y + TILE_H (17 bits).
  - If ny < height: tile_y=ny and go to ISSUE; else go to DONE.
  - tile_w/tile_h are recomputed with clipping on every update.
- Timing: tile_done sampled at edge m gives the next tile_start high after edge m+1.
- DONE: frame_done=1 for 1 cycle, busy=0, go to IDLE.
- ERR: timeout_err=1 (sticky), busy=0, no frame_done, go to IDLE. tiles_completed holds its count.
- frame_start while busy is ignored; no queuing.
- Reset mid-frame returns everything to reset values immediately. No further tile_start is issued.
- tiles_completed saturates at all-ones.

Test Plan:
- 64x64 frame, decoder returns tile_done 5 cycles after tile_start -> one tile_start with (0,0,64,64); frame_done pulse; tiles_completed=1; busy low after.
- 100x70 frame -> tiles in order (0,0,64,64), (64,0,36,64), (0,64,64,6), (64,64,36,6); exactly 4 tile_start pulses; frame_done once; tiles_completed=4.
- 64x64 frame, tile_done never asserted -> timeout_err=1 about 1000 cycles after tile_start; busy=0; frame_done never asserted. A following good frame clears timeout_err.
- frame_width=0 -> no tile_start; frame_done pulses 2 cycles after frame_start; tiles_completed=0.
- Second frame_start during WAIT of a 128x64 frame -> ignored; exactly 2 tiles issued, then frame_done.
- rst_n pulled low during WAIT of 2nd tile -> all outputs 0 asynchronously; after release, no tile_start until a new frame_start.

Source files
------------

// File: rtl/diag_tile_sequencer.sv
// Frame-to-tile sequencer: walks a frame in raster-ordered tiles and issues one
// start per tile to the tile decoder, guarding every tile with a timeout.
module diag_tile_sequencer #(
    parameter int TILE_W         = 64,
    parameter int TILE_H         = 64,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [15:0]      frame_width,
    input  logic [15:0]      frame_height,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err,
    output logic             tile_start,
    output logic [15:0]      tile_x,
    output logic [15:0]      tile_y,
    output logic [15:0]      tile_w,
    output logic [15:0]      tile_h,
    input  logic             tile_done,
    output logic [CNT_W-1:0] tiles_completed
);

    localparam logic [16:0]      TW17     = 17'(TILE_W);
    localparam logic [16:0]      TH17     = 17'(TILE_H);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_d;
    logic [15:0]       width_q, width_d;
    logic [15:0]       height_q, height_d;
    logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_d;
    logic              busy_d, frame_done_d, timeout_err_d, tile_start_d;
    logic [15:0]       tile_x_d, tile_y_d, tile_w_d, tile_h_d;
    logic [CNT_W-1:0]  tiles_d;
    logic [16:0]       nx, ny;

    // Remaining extent from an origin, clipped to the nominal tile size.
    function automatic logic [15:0] clip_dim(input logic [15:0] dim,
                                             input logic [15:0] org,
                                             input logic [16:0] nom);
        logic [16:0] rem;
        rem = {1'b0, dim} - {1'b0, org};
        if (rem > nom) clip_dim = nom[15:0];
        else           clip_dim = rem[15:0];
    endfunction

    always_comb begin
        state_d       = state;
        width_d       = width_q;
        height_d      = height_q;
        tmo_cnt_d     = tmo_cnt;
        busy_d        = busy;
        frame_done_d  = 1'b0;
        timeout_err_d = timeout_err;
        tile_start_d  = 1'b0;
        tile_x_d      = tile_x;
        tile_y_d      = tile_y;
        tile_w_d      = tile_w;
        tile_h_d      = tile_h;
        tiles_d       = tiles_completed;
        nx            = {1'b0, tile_x} + TW17;
        ny            = {1'b0, tile_y} + TH17;

        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    width_d       = frame_width;
                    height_d      = frame_height;
                    timeout_err_d = 1'b0;
                    tiles_d       = '0;
                    busy_d        = 1'b1;
                    if (frame_width == 16'd0 || frame_height == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        tile_x_d     = 16'd0;
                        tile_y_d     = 16'd0;
                        tile_w_d     = clip_dim(frame_width, 16'd0, TW17);
                        tile_h_d     = clip_dim(frame_height, 16'd0, TH17);
                        tile_start_d = 1'b1;
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A completion arriving on the final timeout cycle still counts.
                if (tile_done) begin
                    if (tiles_completed != '1) tiles_d = tiles_completed + CNT_W'(1);
                    state_d = S_NEXT;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt + CNT_W'(1);
                end
            end
            S_NEXT: begin
                if (nx < {1'b0, width_q}) begin
                    tile_x_d     = nx[15:0];
                    tile_w_d     = clip_dim(width_q, nx[15:0], TW17);
                    tile_start_d = 1'b1;
                    state_d      = S_ISSUE;
                end else begin
                    tile_x_d = 16'd0;
                    tile_w_d = clip_dim(width_q, 16'd0, TW17);
                    if (ny < {1'b0, height_q}) begin
                        tile_y_d     = ny[15:0];
                        tile_h_d     = clip_dim(height_q, ny[15:0], TH17);
                        tile_start_d = 1'b1;
                        state_d      = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            S_ERR: begin
                timeout_err_d = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            width_q         <= '0;
            height_q        <= '0;
            tmo_cnt         <= '0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            timeout_err     <= 1'b0;
            tile_start      <= 1'b0;
            tile_x          <= '0;
            tile_y          <= '0;
            tile_w          <= '0;
            tile_h          <= '0;
            tiles_completed <= '0;
        end else begin
            state           <= state_d;
            width_q         <= width_d;
            height_q        <= height_d;
            tmo_cnt         <= tmo_cnt_d;
            busy            <= busy_d;
            frame_done      <= frame_done_d;
            timeout_err     <= timeout_err_d;
            tile_start      <= tile_start_d;
            tile_x          <= tile_x_d;
            tile_y          <= tile_y_d;
            tile_w          <= tile_w_d;
            tile_h          <= tile_h_d;
            tiles_completed <= tiles_d;
        end
    end

endmodule

// File: tb/tb_diag_tile_sequencer.sv
// Scoreboard bench for diag_tile_sequencer: a raster-walk model predicts tiles and
// frame outcomes, a negedge monitor checks every tile_start / frame_done / error.
module tb_diag_tile_sequencer;

    localparam int TILE_W = 64;
    localparam int TILE_H = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [15:0] frame_width, frame_height;
    logic        busy, frame_done, timeout_err, tile_start;
    logic [15:0] tile_x, tile_y, tile_w, tile_h;
    logic        tile_done;
    logic [15:0] tiles_completed;

    diag_tile_sequencer #(
        .TILE_W(TILE_W), .TILE_H(TILE_H), .TIMEOUT_CYCLES(1000), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .frame_width(frame_width), .frame_height(frame_height),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
        .tile_start(tile_start), .tile_x(tile_x), .tile_y(tile_y),
        .tile_w(tile_w), .tile_h(tile_h), .tile_done(tile_done),
        .tiles_completed(tiles_completed)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int w; int h; } tile_t;
    typedef struct { int cnt; bit tmo; } frame_t;

    tile_t  exp_tiles[$];
    frame_t exp_frames[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ts_cnt = 0, done_ev = 0, err_ev = 0;
    int last_ts_cyc = 0, last_err_cyc = 0;
    bit dec_en = 1'b1;
    int dec_lo = 1, dec_hi = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: raster walk of the frame in nominal tile steps, clipped at the edges.
    task automatic push_frame(input int w, input int h, input bit decoder_on);
        int n;
        tile_t t;
        frame_t f;
        n = 0;
        if (w > 0 && h > 0) begin
            for (int y = 0; y < h; y += TILE_H) begin
                for (int x = 0; x < w; x += TILE_W) begin
                    t.x = x; t.y = y;
                    t.w = (w - x < TILE_W) ? w - x : TILE_W;
                    t.h = (h - y < TILE_H) ? h - y : TILE_H;
                    if (decoder_on || n == 0) exp_tiles.push_back(t);
                    n++;
                end
            end
        end
        f.tmo = (w > 0 && h > 0 && !decoder_on);
        f.cnt = f.tmo ? 0 : n;
        exp_frames.push_back(f);
    endtask

    task automatic pulse_start(input int w, input int h);
        @(posedge clk); #1;
        frame_width  = 16'(w);
        frame_height = 16'(h);
        frame_start  = 1'b1;
        @(posedge clk); #1;
        frame_start  = 1'b0;
    endtask

    task automatic start_frame(input int w, input int h);
        push_frame(w, h, dec_en);
        pulse_start(w, h);
    endtask

    task automatic wait_end(input int base, input int limit);
        bit got;
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk); #1;
            got = ((done_ev + err_ev) != base);
        end
        check("frame_end_seen", {63'd0, got}, 64'd1);
    endtask

    // Tile decoder model: one tile_done pulse a random delay after each tile_start.
    initial begin
        int d;
        tile_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tile_start && dec_en) begin
                d = $urandom_range(dec_hi, dec_lo);
                repeat (d) @(posedge clk);
                #1 tile_done = 1'b1;
                @(posedge clk);
                #1 tile_done = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        bit err_q, fd_q;
        tile_t t;
        frame_t f;
        err_q = 1'b0;
        fd_q  = 1'b0;
        forever begin
            @(negedge clk);
            if (tile_start) begin
                ts_cnt++;
                last_ts_cyc = cyc;
                if (exp_tiles.size() == 0) begin
                    check("unexpected_tile_start", 64'd1, 64'd0);
                end else begin
                    t = exp_tiles.pop_front();
                    check("tile_geom", {tile_x, tile_y, tile_w, tile_h},
                          {16'(t.x), 16'(t.y), 16'(t.w), 16'(t.h)});
                end
            end
            if (frame_done) begin
                done_ev++;
                check("frame_done_one_cycle", {63'd0, fd_q}, 64'd0);
                if (exp_frames.size() == 0) begin
                    check("unexpected_frame_done", 64'd1, 64'd0);
                end else begin
                    f = exp_frames.pop_front();
                    check("frame_done_not_timeout", {63'd0, f.tmo}, 64'd0);
                    check("done_tiles_completed", 64'(tiles_completed), 64'(f.cnt));
                    check("busy_low_at_done", {63'd0, busy}, 64'd0);
                    check("tiles_all_issued", 64'(exp_tiles.size()), 64'd0);
                    check("err_clear_at_done", {63'd0, timeout_err}, 64'd0);
                end
            end
            if (timeout_err && !err_q) begin
                err_ev++;
                last_err_cyc = cyc;
                if (exp_frames.size() == 0) begin
                    check("unexpected_timeout", 64'd1, 64'd0);
                end else begin
                    f = exp_frames.pop_front();
                    check("timeout_expected", {63'd0, f.tmo}, 64'd1);
                    check("err_tiles_completed", 64'(tiles_completed), 64'(f.cnt));
                    check("busy_low_at_err", {63'd0, busy}, 64'd0);
                end
            end
            err_q = timeout_err;
            fd_q  = frame_done;
        end
    end

    initial begin
        int base, ts0, w, h;
        rst_n        = 1'b0;
        frame_start  = 1'b0;
        frame_width  = '0;
        frame_height = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {44'd0, busy, frame_done, timeout_err, tile_start, tiles_completed}, 64'd0);
        check("reset_geom", {tile_x, tile_y, tile_w, tile_h}, 64'd0);
        rst_n = 1'b1;

        // Single full tile
        dec_lo = 5; dec_hi = 5;
        base = done_ev + err_ev;
        start_frame(64, 64);
        wait_end(base, 200);

        // Clipped right/bottom edges
        dec_lo = 1; dec_hi = 6;
        ts0 = ts_cnt; base = done_ev + err_ev;
        start_frame(100, 70);
        wait_end(base, 300);
        check("tiles_100x70", 64'(ts_cnt - ts0), 64'd4);

        // Decoder silent: timeout, then a good frame clears the error
        dec_en = 1'b0;
        base = done_ev + err_ev;
        start_frame(64, 64);
        wait_end(base, 1500);
        check($sformatf("timeout_latency_%0d", last_err_cyc - last_ts_cyc),
              {63'd0, (last_err_cyc - last_ts_cyc >= 995 && last_err_cyc - last_ts_cyc <= 1010)}, 64'd1);
        check("timeout_err_sticky", {63'd0, timeout_err}, 64'd1);
        dec_en = 1'b1;
        base = done_ev + err_ev;
        start_frame(64, 64);
        check("err_cleared_on_accept", {63'd0, timeout_err}, 64'd0);
        wait_end(base, 200);

        // Zero width: frame_done two cycles after frame_start, no tiles
        ts0 = ts_cnt; base = done_ev + err_ev;
        start_frame(0, 50);
        @(posedge clk); #1;
        check("zero_dim_done_latency", {63'd0, frame_done}, 64'd1);
        wait_end(base, 20);
        check("zero_dim_no_tiles", 64'(ts_cnt - ts0), 64'd0);

        // frame_start while busy is ignored
        dec_lo = 10; dec_hi = 10;
        ts0 = ts_cnt; base = done_ev + err_ev;
        start_frame(128, 64);
        repeat (4) @(posedge clk);
        pulse_start(64, 64);
        wait_end(base, 300);
        repeat (30) @(posedge clk);
        #1;
        check("busy_start_ignored_tiles", 64'(ts_cnt - ts0), 64'd2);
        check("busy_start_ignored_frames", 64'(done_ev + err_ev - base), 64'd1);

        // Asynchronous reset during WAIT of the second tile
        dec_lo = 8; dec_hi = 8;
        ts0 = ts_cnt;
        start_frame(128, 64);
        for (int i = 0; i < 100 && ts_cnt < ts0 + 2; i++) @(negedge clk);
        check("second_tile_reached", 64'(ts_cnt - ts0), 64'd2);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {44'd0, busy, frame_done, timeout_err, tile_start, tiles_completed}, 64'd0);
        check("async_reset_geom", {tile_x, tile_y, tile_w, tile_h}, 64'd0);
        exp_tiles.delete();
        exp_frames.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        ts0 = ts_cnt;
        repeat (25) @(posedge clk);
        #1;
        check("no_tile_after_reset", 64'(ts_cnt - ts0), 64'd0);
        check("idle_after_reset", {63'd0, busy}, 64'd0);

        // Randomized frames against the raster model
        for (int k = 0; k < 20; k++) begin
            w = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(300, 1));
            h = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(200, 1));
            dec_lo = 1;
            dec_hi = $urandom_range(6, 1);
            base = done_ev + err_ev;
            start_frame(w, h);
            wait_end(base, 5000);
        end

        // Full-width row: the last tile step crosses 16 bits
        dec_lo = 1; dec_hi = 1;
        ts0 = ts_cnt; base = done_ev + err_ev;
        start_frame(65535, 1);
        wait_end(base, 20000);
        check("wide_row_tiles", 64'(ts_cnt - ts0), 64'd1024);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_tiles_drained", 64'(exp_tiles.size()), 64'd0);
        check("scoreboard_frames_drained", 64'(exp_frames.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
